// File: rtl/wb_writeback_arb_if.sv
// Writeback arbiter bundle: two producer handshakes, write-port outputs, hazard query.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

interface wb_writeback_arb_if #(
  parameter int DEPTH       = 4,
  parameter int XLEN        = `XLEN,
  parameter int RFIDX_WIDTH = `RFIDX_WIDTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   alu_valid;
  logic                   alu_ready;
  logic [RFIDX_WIDTH-1:0] alu_rd;
  logic [XLEN-1:0]        alu_data;
  logic                   ld_valid;
  logic                   ld_ready;
  logic [RFIDX_WIDTH-1:0] ld_rd;
  logic [XLEN-1:0]        ld_data;
  logic                   wp_stall;
  logic                   we3;
  logic [RFIDX_WIDTH-1:0] wa3;
  logic [XLEN-1:0]        wd3;
  logic [RFIDX_WIDTH-1:0] qa;
  logic                   q_busy;
  logic [CW-1:0]          count;
  logic                   full;
  logic                   empty;

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, wp_stall, qa,
    output alu_ready, ld_ready, we3, wa3, wd3, q_busy, count, full, empty
  );

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, wp_stall, qa,
    input  alu_ready, ld_ready, we3, wa3, wd3, q_busy, count, full, empty
  );
endinterface

// File: rtl/wb_writeback_arb.sv
// Round-robin ALU/load writeback arbiter feeding an in-order FIFO that drains into the
// register-file write port; WB_BYPASS_EN lets an entry skip an empty FIFO (1-edge latency).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

module wb_writeback_arb #(
  parameter int DEPTH       = 4,
  parameter int XLEN        = `XLEN,
  parameter int RFIDX_WIDTH = `RFIDX_WIDTH
) (
  input logic                 clk,
  input logic                 rstn,
  wb_writeback_arb_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic                   rr_ld_q, rr_ld_d;  // 1: load wins a tie
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [RFIDX_WIDTH-1:0] mem_rd_q   [DEPTH];
  logic [XLEN-1:0]        mem_data_q [DEPTH];
  logic                   we3_q, we3_d;
  logic [RFIDX_WIDTH-1:0] wa3_q, wa3_d;
  logic [XLEN-1:0]        wd3_q, wd3_d;

  logic                   can_acc, alu_gnt, ld_gnt, acc, push, pop, bypass;
  logic [RFIDX_WIDTH-1:0] acc_rd;
  logic [XLEN-1:0]        acc_data;
  logic                   hit;
  logic [AW-1:0]          idx;

  // Readiness never looks at the same-cycle pop, so a full FIFO refuses even while draining.
  always_comb begin
    can_acc  = rstn && (count_q < DEPTH_C);
    ld_gnt   = can_acc && bus.ld_valid && (!bus.alu_valid || rr_ld_q);
    alu_gnt  = can_acc && bus.alu_valid && !(bus.ld_valid && rr_ld_q);
    acc      = alu_gnt || ld_gnt;
    acc_rd   = ld_gnt ? bus.ld_rd : bus.alu_rd;
    acc_data = ld_gnt ? bus.ld_data : bus.alu_data;
    pop      = !bus.wp_stall && (count_q != '0);
`ifdef WB_BYPASS_EN
    bypass   = acc && (acc_rd != '0) && (count_q == '0) && !bus.wp_stall;
`else
    bypass   = 1'b0;
`endif
    push     = acc && (acc_rd != '0) && !bypass;
  end

  always_comb begin
    rr_ld_d  = rr_ld_q;
    if (alu_gnt)     rr_ld_d = 1'b1;
    else if (ld_gnt) rr_ld_d = 1'b0;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    we3_d = 1'b0;
    wa3_d = wa3_q;
    wd3_d = wd3_q;
    if (pop) begin
      we3_d = 1'b1;
      wa3_d = mem_rd_q[rd_ptr_q];
      wd3_d = mem_data_q[rd_ptr_q];
    end else if (bypass) begin
      we3_d = 1'b1;
      wa3_d = acc_rd;
      wd3_d = acc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ld_q  <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
    end else begin
      rr_ld_q  <= rr_ld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd_q[wr_ptr_q]   <= acc_rd;
      mem_data_q[wr_ptr_q] <= acc_data;
    end
  end

  // Only the count_q entries starting at the read pointer are live.
  always_comb begin
    hit = we3_q && (wa3_q == bus.qa);
    idx = rd_ptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + AW'(k);
      if ((CW'(k) < count_q) && (mem_rd_q[idx] == bus.qa)) hit = 1'b1;
    end
  end

  assign bus.q_busy    = hit && (bus.qa != '0);
  assign bus.alu_ready = alu_gnt;
  assign bus.ld_ready  = ld_gnt;
  assign bus.we3       = we3_q;
  assign bus.wa3       = wa3_q;
  assign bus.wd3       = wd3_q;
  assign bus.count     = count_q;
  assign bus.full      = (count_q == DEPTH_C);
  assign bus.empty     = (count_q == '0);

endmodule
